mips_multicycle_control: RTL

//  Main control FSM of the multi-cycle MIPS datapath; drives the ALU-control decoder through alu_op.

---
 rtl/mips_ctrl_pkg.sv | 59 +++++
 rtl/mips_ctrl_decode.sv | 71 +++++++
 rtl/mips_multicycle_control.sv | 106 ++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control FSM: opcodes,
// datapath select codes, state enumeration and the control-word struct.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUSRCB_B      = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_BRANCH = 4'd11,
        S_JUMP   = 4'd12,
        S_TRAP   = 4'd13
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       illegal_op;
    } ctrl_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Pure output table: maps the registered control state (and the effective
// memory-ready) onto the datapath control word.
module mips_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_rdy,
    output ctrl_t  ctrl
);

    // Per-state control word; unlisted encodings leave every output low
    always_comb begin
        ctrl = '0;
        case (state)
            S_RESET: ctrl = '0;
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = mem_rdy;
                ctrl.pc_write  = mem_rdy;
                ctrl.alu_src_b = ALUSRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_src    = PCSRC_ALU;
            end
            S_DECODE: ctrl.alu_src_b = ALUSRCB_IMM_SH;
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUSRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUSRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
            end
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUSRCB_IMM;
            end
            S_ADDIWB: ctrl.reg_write = 1'b1;
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = ALUSRCB_B;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_src        = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PCSRC_JUMP;
            end
            S_TRAP: ctrl.illegal_op = 1'b1;
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM of the multi-cycle MIPS datapath: state register and
// opcode-driven next-state logic; outputs come from mips_ctrl_decode.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter logic ENABLE_ADDI = 1'b1,
    parameter logic MEM_WAIT    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       illegal_op,
    output logic [3:0] state_o
);

    state_t state_q;
    state_t state_d;
    logic   mem_rdy_s;
    ctrl_t  ctrl_s;

    assign mem_rdy_s = MEM_WAIT ? mem_ready : 1'b1;

    // Next-state selection; unreachable encodings recover through FETCH
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH: begin
                if (mem_rdy_s) state_d = S_DECODE;
                else           state_d = S_FETCH;
            end
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI: begin
                        if (ENABLE_ADDI) state_d = S_ADDIEX;
                        else             state_d = S_TRAP;
                    end
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_SW) state_d = S_MEMWR;
                else                 state_d = S_MEMRD;
            end
            S_MEMRD: begin
                if (mem_rdy_s) state_d = S_MEMWB;
                else           state_d = S_MEMRD;
            end
            S_MEMWR: begin
                if (mem_rdy_s) state_d = S_FETCH;
                else           state_d = S_MEMWR;
            end
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH, S_JUMP, S_TRAP: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_RESET;
        else        state_q <= state_d;
    end

    mips_ctrl_decode u_decode (
        .state   (state_q),
        .mem_rdy (mem_rdy_s),
        .ctrl    (ctrl_s)
    );

    assign pc_write      = ctrl_s.pc_write;
    assign pc_write_cond = ctrl_s.pc_write_cond;
    assign i_or_d        = ctrl_s.i_or_d;
    assign mem_read      = ctrl_s.mem_read;
    assign mem_write     = ctrl_s.mem_write;
    assign ir_write      = ctrl_s.ir_write;
    assign mem_to_reg    = ctrl_s.mem_to_reg;
    assign reg_dst       = ctrl_s.reg_dst;
    assign reg_write     = ctrl_s.reg_write;
    assign alu_src_a     = ctrl_s.alu_src_a;
    assign alu_src_b     = ctrl_s.alu_src_b;
    assign alu_op        = ctrl_s.alu_op;
    assign pc_src        = ctrl_s.pc_src;
    assign illegal_op    = ctrl_s.illegal_op;
    assign state_o       = state_q;

endmodule
